// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control path:
// opcode/funct constants, ALU selector codes, mux encodings and the FSM state enum.
package mips_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU selector codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU operand B source
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Next-PC source
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Control states; encodings 13..15 are never entered.
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADR    = 4'd2,
        S_MEMRD     = 4'd3,
        S_MEMWB     = 4'd4,
        S_MEMWR     = 4'd5,
        S_RTYPE_EX  = 4'd6,
        S_RTYPE_WB  = 4'd7,
        S_BRANCH    = 4'd8,
        S_ADDI_EX   = 4'd9,
        S_ADDI_WB   = 4'd10,
        S_JUMP      = 4'd11,
        S_BRANCH_NE = 4'd12
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational funct -> ALU selector decoder. Outside R-type execution it
// answers ADD and never flags an illegal funct.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    input  logic       is_rtype,
    output logic [2:0] selector,
    output logic       funct_illegal
);

    // Map funct to an ALU operation; unknown funct falls back to ADD and is flagged
    always_comb begin
        selector      = ALU_ADD;
        funct_illegal = 1'b0;
        if (is_rtype) begin
            case (funct)
                FUNCT_AND: selector = ALU_AND;
                FUNCT_OR:  selector = ALU_OR;
                FUNCT_ADD: selector = ALU_ADD;
                FUNCT_SUB: selector = ALU_SUB;
                FUNCT_SLT: selector = ALU_SLT;
                default: begin
                    selector      = ALU_ADD;
                    funct_illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/control_multiciclo.sv
// Multi-cycle MIPS-subset control FSM. One state per clock; drives every
// datapath select/enable. Optional bne support is compiled in with CONTROL_BNE_EN.
module control_multiciclo
    import mips_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zf,
    output logic [2:0]         selector,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_src,
    output logic               pc_we,
    output logic               ir_we,
    output logic               iord,
    output logic               mem_we,
    output logic               reg_we,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               illegal_op,
    output logic [STATE_W-1:0] estado
);

    state_t     state_reg;
    state_t     state_next;
    logic [2:0] dec_selector;
    logic       dec_illegal;
    logic       pc_we_c;
    logic       ir_we_c;
    logic       mem_we_c;
    logic       reg_we_c;
    logic       illegal_c;

    alu_decoder u_alu_decoder (
        .funct         (funct),
        .is_rtype      (state_reg == S_RTYPE_EX),
        .selector      (dec_selector),
        .funct_illegal (dec_illegal)
    );

    // State register; reset drops straight back to FETCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and per-state output decode; everything defaults to 0
    always_comb begin
        state_next = S_FETCH;
        selector   = ALU_AND;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        pc_src     = PCSRC_ALU;
        pc_we_c    = 1'b0;
        ir_we_c    = 1'b0;
        iord       = 1'b0;
        mem_we_c   = 1'b0;
        reg_we_c   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal_c  = 1'b0;
        case (state_reg)
            S_FETCH: begin
                ir_we_c    = 1'b1;
                pc_we_c    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                selector   = ALU_ADD;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut here
                alu_src_b = SRCB_IMM_SH;
                selector  = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_RTYPE_EX;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDI_EX;
                    OP_J:         state_next = S_JUMP;
`ifdef CONTROL_BNE_EN
                    OP_BNE:       state_next = S_BRANCH_NE;
`endif
                    default: begin
                        illegal_c  = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                selector   = ALU_ADD;
                state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                reg_we_c   = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                mem_we_c = 1'b1;
            end
            S_RTYPE_EX: begin
                alu_src_a  = 1'b1;
                selector   = dec_selector;
                illegal_c  = dec_illegal;
                state_next = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                reg_we_c = 1'b1;
                reg_dst  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                selector  = ALU_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_we_c   = zf;
            end
            S_ADDI_EX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                selector   = ALU_ADD;
                state_next = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_we_c = 1'b1;
            end
            S_JUMP: begin
                pc_src  = PCSRC_JUMP;
                pc_we_c = 1'b1;
            end
`ifdef CONTROL_BNE_EN
            S_BRANCH_NE: begin
                alu_src_a = 1'b1;
                selector  = ALU_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_we_c   = ~zf;
            end
`endif
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // While reset is held no write or illegal pulse may escape; the state
    // register is already FETCH so the remaining outputs show FETCH values
    always_comb begin
        pc_we      = pc_we_c   & ~rst;
        ir_we      = ir_we_c   & ~rst;
        mem_we     = mem_we_c  & ~rst;
        reg_we     = reg_we_c  & ~rst;
        illegal_op = illegal_c & ~rst;
    end

    assign estado = STATE_W'(state_reg);

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed testbench for control_multiciclo. Outputs are packed into one
// 20-bit vector and compared once per cycle against hand-built expectations.
// Vector layout: {estado[3:0], selector[2:0], alu_src_a, alu_src_b[1:0], pc_src[1:0],
//                 pc_we, ir_we, iord, mem_we, reg_we, reg_dst, mem_to_reg, illegal_op}
// Honors CONTROL_BNE_EN to select the expected bne behaviour.
module tb_control_multiciclo;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zf;
    logic [2:0] selector;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_we, ir_we, iord, mem_we, reg_we, reg_dst, mem_to_reg, illegal_op;
    logic [3:0] estado;
    logic [19:0] obs;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [19:0] V_RESET      = {4'd0,  3'b010, 1'b0, 2'b01, 2'b00, 8'b0000_0000};
    localparam logic [19:0] V_FETCH      = {4'd0,  3'b010, 1'b0, 2'b01, 2'b00, 8'b1100_0000};
    localparam logic [19:0] V_DECODE     = {4'd1,  3'b010, 1'b0, 2'b11, 2'b00, 8'b0000_0000};
    localparam logic [19:0] V_DECODE_ILL = {4'd1,  3'b010, 1'b0, 2'b11, 2'b00, 8'b0000_0001};
    localparam logic [19:0] V_MEMADR     = {4'd2,  3'b010, 1'b1, 2'b10, 2'b00, 8'b0000_0000};
    localparam logic [19:0] V_MEMRD      = {4'd3,  3'b000, 1'b0, 2'b00, 2'b00, 8'b0010_0000};
    localparam logic [19:0] V_MEMWB      = {4'd4,  3'b000, 1'b0, 2'b00, 2'b00, 8'b0000_1010};
    localparam logic [19:0] V_MEMWR      = {4'd5,  3'b000, 1'b0, 2'b00, 2'b00, 8'b0011_0000};
    localparam logic [19:0] V_RTYPE_WB   = {4'd7,  3'b000, 1'b0, 2'b00, 2'b00, 8'b0000_1100};
    localparam logic [19:0] V_BEQ_TAKEN  = {4'd8,  3'b110, 1'b1, 2'b00, 2'b01, 8'b1000_0000};
    localparam logic [19:0] V_BEQ_NOT    = {4'd8,  3'b110, 1'b1, 2'b00, 2'b01, 8'b0000_0000};
    localparam logic [19:0] V_ADDI_EX    = {4'd9,  3'b010, 1'b1, 2'b10, 2'b00, 8'b0000_0000};
    localparam logic [19:0] V_ADDI_WB    = {4'd10, 3'b000, 1'b0, 2'b00, 2'b00, 8'b0000_1000};
    localparam logic [19:0] V_JUMP       = {4'd11, 3'b000, 1'b0, 2'b00, 2'b10, 8'b1000_0000};
    localparam logic [19:0] V_BNE_TAKEN  = {4'd12, 3'b110, 1'b1, 2'b00, 2'b01, 8'b1000_0000};
    localparam logic [19:0] V_BNE_NOT    = {4'd12, 3'b110, 1'b1, 2'b00, 2'b01, 8'b0000_0000};

    control_multiciclo #(.STATE_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zf         (zf),
        .selector   (selector),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .iord       (iord),
        .mem_we     (mem_we),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal_op (illegal_op),
        .estado     (estado)
    );

    assign obs = {estado, selector, alu_src_a, alu_src_b, pc_src,
                  pc_we, ir_we, iord, mem_we, reg_we, reg_dst, mem_to_reg, illegal_op};

    always #5 clk = ~clk;

    // Reset at power-up, then a lw interrupted by a mid-cycle reset in DECODE
    task automatic test_reset();
        rst = 1'b1; opcode = 6'b000000; funct = 6'b000000; zf = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (obs !== V_RESET) begin
            n_errors++;
            $display("FAIL reset_hold: got %05h expected %05h", obs, V_RESET);
        end
        rst = 1'b0;
        opcode = 6'b100011;
        #1;
        n_checks++;
        if (obs !== V_FETCH) begin
            n_errors++;
            $display("FAIL reset_release_fetch: got %05h expected %05h", obs, V_FETCH);
        end
        @(posedge clk);
        #3;
        n_checks++;
        if (obs !== V_DECODE) begin
            n_errors++;
            $display("FAIL pre_abort_decode: got %05h expected %05h", obs, V_DECODE);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== V_RESET) begin
            n_errors++;
            $display("FAIL reset_mid_cycle: got %05h expected %05h", obs, V_RESET);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (obs !== V_RESET) begin
            n_errors++;
            $display("FAIL reset_across_edge: got %05h expected %05h", obs, V_RESET);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("reset: done");
    endtask

    task automatic test_lw();
        logic [19:0] exp_seq [5];
        exp_seq = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB};
        opcode = 6'b100011; funct = 6'b000000; zf = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            n_checks++;
            if (obs !== exp_seq[k]) begin
                n_errors++;
                $display("FAIL lw_cycle%0d: got %05h expected %05h", k + 1, obs, exp_seq[k]);
            end
        end
        @(negedge clk);
        $display("lw: 5 cycles checked");
    endtask

    task automatic test_sw();
        logic [19:0] exp_seq [5];
        exp_seq = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR, V_FETCH};
        opcode = 6'b101011; funct = 6'b000000; zf = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            n_checks++;
            if (obs !== exp_seq[k]) begin
                n_errors++;
                $display("FAIL sw_cycle%0d: got %05h expected %05h", k + 1, obs, exp_seq[k]);
            end
        end
        $display("sw: 4 cycles plus return to FETCH checked");
    endtask

    task automatic test_rtype();
        logic [5:0]  f_tab   [6];
        logic [2:0]  s_tab   [6];
        logic        i_tab   [6];
        logic [19:0] exp_seq [4];
        f_tab = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010, 6'b000111};
        s_tab = '{3'b000,    3'b001,    3'b010,    3'b110,    3'b111,    3'b010};
        i_tab = '{1'b0,      1'b0,      1'b0,      1'b0,      1'b0,      1'b1};
        for (int t = 0; t < 6; t++) begin
            opcode = 6'b000000; funct = f_tab[t]; zf = 1'b0;
            exp_seq = '{V_FETCH, V_DECODE,
                        {4'd6, s_tab[t], 1'b1, 2'b00, 2'b00, 7'b000_0000, i_tab[t]},
                        V_RTYPE_WB};
            #1;
            for (int k = 0; k < 4; k++) begin
                if (k > 0) begin @(negedge clk); #1; end
                n_checks++;
                if (obs !== exp_seq[k]) begin
                    n_errors++;
                    $display("FAIL rtype_funct%06b_cycle%0d: got %05h expected %05h",
                             f_tab[t], k + 1, obs, exp_seq[k]);
                end
            end
            @(negedge clk);
            $display("rtype: funct=%06b checked", f_tab[t]);
        end
    endtask

    task automatic test_beq();
        logic [19:0] exp_seq [4];
        for (int t = 0; t < 2; t++) begin
            opcode = 6'b000100; funct = 6'b000000; zf = (t == 0);
            exp_seq = '{V_FETCH, V_DECODE, (t == 0) ? V_BEQ_TAKEN : V_BEQ_NOT, V_FETCH};
            #1;
            for (int k = 0; k < 4; k++) begin
                if (k > 0) begin @(negedge clk); #1; end
                n_checks++;
                if (obs !== exp_seq[k]) begin
                    n_errors++;
                    $display("FAIL beq_zf%0d_cycle%0d: got %05h expected %05h",
                             zf, k + 1, obs, exp_seq[k]);
                end
            end
            $display("beq: zf=%0d checked", zf);
        end
    endtask

    task automatic test_addi();
        logic [19:0] exp_seq [5];
        exp_seq = '{V_FETCH, V_DECODE, V_ADDI_EX, V_ADDI_WB, V_FETCH};
        opcode = 6'b001000; funct = 6'b000000; zf = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            n_checks++;
            if (obs !== exp_seq[k]) begin
                n_errors++;
                $display("FAIL addi_cycle%0d: got %05h expected %05h", k + 1, obs, exp_seq[k]);
            end
        end
        $display("addi: checked");
    endtask

    task automatic test_jump();
        logic [19:0] exp_seq [4];
        exp_seq = '{V_FETCH, V_DECODE, V_JUMP, V_FETCH};
        opcode = 6'b000010; funct = 6'b000000; zf = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            n_checks++;
            if (obs !== exp_seq[k]) begin
                n_errors++;
                $display("FAIL jump_cycle%0d: got %05h expected %05h", k + 1, obs, exp_seq[k]);
            end
        end
        $display("j: checked");
    endtask

    task automatic test_illegal_opcode();
        logic [19:0] exp_seq [3];
        exp_seq = '{V_FETCH, V_DECODE_ILL, V_FETCH};
        opcode = 6'b111111; funct = 6'b000000; zf = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            n_checks++;
            if (obs !== exp_seq[k]) begin
                n_errors++;
                $display("FAIL illegal_op_cycle%0d: got %05h expected %05h", k + 1, obs, exp_seq[k]);
            end
        end
        $display("illegal opcode: checked");
    endtask

    task automatic test_bne();
        logic [19:0] exp_seq [4];
        for (int t = 0; t < 2; t++) begin
            opcode = 6'b000101; funct = 6'b000000; zf = (t == 1);
`ifdef CONTROL_BNE_EN
            exp_seq = '{V_FETCH, V_DECODE, (t == 0) ? V_BNE_TAKEN : V_BNE_NOT, V_FETCH};
`else
            exp_seq = '{V_FETCH, V_DECODE_ILL, V_FETCH, V_DECODE_ILL};
`endif
            #1;
            for (int k = 0; k < 4; k++) begin
                if (k > 0) begin @(negedge clk); #1; end
                n_checks++;
                if (obs !== exp_seq[k]) begin
                    n_errors++;
                    $display("FAIL bne_zf%0d_cycle%0d: got %05h expected %05h",
                             zf, k + 1, obs, exp_seq[k]);
                end
            end
            // Realign to the middle of a FETCH cycle
`ifndef CONTROL_BNE_EN
            @(negedge clk);
`endif
            $display("bne: zf=%0d checked", zf);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_beq();
        test_addi();
        test_jump();
        test_illegal_opcode();
        test_bne();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
